// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by the hazard_unit top and its multiply-stall FSM.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_LAST = 2'd2
    } mul_state_t;

    localparam int unsigned ZERO_ADDRESS = 0;
    localparam int unsigned STALL_CNT_W  = 32;

endpackage

// File: rtl/mul_stall_fsm.sv
// Multi-cycle multiply freeze sequencer.
// Holds IF/ID/EX frozen for MulLatency-1 cycles per accepted start.
module mul_stall_fsm
    import hazard_unit_pkg::*;
#(
    parameter int MulLatency = 4
) (
    input  logic clk,
    input  logic arst_n,
    input  logic i_start,
    output logic o_busy
);

    localparam bit         Enabled  = (MulLatency >= 2);
    localparam int         LoadVal  = Enabled ? MulLatency - 2 : 0;
    localparam mul_state_t FirstSt  =
        (MulLatency > 2) ? MUL_BUSY : MUL_LAST;

    mul_state_t r_state;
    mul_state_t w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_accept;

    // Starts are only honoured in RUN, so the release cycle ignores them
    assign w_accept = i_start & Enabled & (r_state == RUN);
    assign o_busy   = w_accept | (r_state == MUL_BUSY);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RUN: begin
                if (w_accept) begin
                    w_state_nxt = FirstSt;
                    w_cnt_nxt   = 4'(LoadVal);
                end
            end
            MUL_BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = MUL_LAST;
                end
            end
            MUL_LAST: w_state_nxt = RUN;
            default:  w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller: load-use bubble, multiply freeze,
// taken-branch flush, plus a saturating stall-cycle counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int AddressSize = 5,
    parameter int MulLatency  = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [AddressSize-1:0] IDRs1,
    input  logic [AddressSize-1:0] IDRs2,
    input  logic                   IDUsesRs1,
    input  logic                   IDUsesRs2,
    input  logic [AddressSize-1:0] EXRegisterRd,
    input  logic                   EXMemRead,
    input  logic                   EXMulStart,
    input  logic                   branchTaken,
    output logic                   pcWrite,
    output logic                   ifIdWrite,
    output logic                   idExWrite,
    output logic                   idExBubble,
    output logic                   ifIdFlush,
    output logic                   exMemBubble,
    output logic                   mulBusy,
    output logic [STALL_CNT_W-1:0] stallCycles
);

    logic                   w_loadUse;
    logic                   w_rs1Hit;
    logic                   w_rs2Hit;
    logic                   w_mulReq;
    logic                   w_mulBusy;
    logic [STALL_CNT_W-1:0] r_stallCycles;

    assign w_rs1Hit = IDUsesRs1 & (IDRs1 == EXRegisterRd);
    assign w_rs2Hit = IDUsesRs2 & (IDRs2 == EXRegisterRd);
    assign w_loadUse = EXMemRead
        & (EXRegisterRd != AddressSize'(ZERO_ADDRESS))
        & (w_rs1Hit | w_rs2Hit);

    // A taken branch outranks a multiply start in RUN
    assign w_mulReq = EXMulStart & ~branchTaken;

    mul_stall_fsm #(
        .MulLatency(MulLatency)
    ) u_mul_fsm (
        .clk    (clk),
        .arst_n (arst_n),
        .i_start(w_mulReq),
        .o_busy (w_mulBusy)
    );

    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        idExWrite   = 1'b1;
        idExBubble  = 1'b0;
        ifIdFlush   = 1'b0;
        exMemBubble = 1'b0;
        if (w_mulBusy) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExWrite   = 1'b0;
            exMemBubble = 1'b1;
        end else if (branchTaken) begin
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
        end else if (w_loadUse) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
        end
    end

    assign mulBusy = w_mulBusy;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stallCycles <= '0;
        end else if (!pcWrite && (r_stallCycles != '1)) begin
            r_stallCycles <= r_stallCycles + 1'b1;
        end
    end

    assign stallCycles = r_stallCycles;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomised + directed bench for hazard_unit at MulLatency 4, 2, 1
// against a cycle-count reference model.
module tb_hazard_unit;

    logic       clk;
    logic       arst_n;
    logic [4:0] IDRs1;
    logic [4:0] IDRs2;
    logic       IDUsesRs1;
    logic       IDUsesRs2;
    logic [4:0] EXRegisterRd;
    logic       EXMemRead;
    logic       EXMulStart;
    logic       branchTaken;

    logic        pcW   [3];
    logic        ifIdW [3];
    logic        idExW [3];
    logic        idExB [3];
    logic        ifIdF [3];
    logic        exMemB[3];
    logic        mulB  [3];
    logic [31:0] stC   [3];

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit #(.AddressSize(5), .MulLatency(4)) u4 (
        .clk(clk), .arst_n(arst_n),
        .IDRs1(IDRs1), .IDRs2(IDRs2),
        .IDUsesRs1(IDUsesRs1), .IDUsesRs2(IDUsesRs2),
        .EXRegisterRd(EXRegisterRd), .EXMemRead(EXMemRead),
        .EXMulStart(EXMulStart), .branchTaken(branchTaken),
        .pcWrite(pcW[0]), .ifIdWrite(ifIdW[0]),
        .idExWrite(idExW[0]), .idExBubble(idExB[0]),
        .ifIdFlush(ifIdF[0]), .exMemBubble(exMemB[0]),
        .mulBusy(mulB[0]), .stallCycles(stC[0])
    );

    hazard_unit #(.AddressSize(5), .MulLatency(2)) u2 (
        .clk(clk), .arst_n(arst_n),
        .IDRs1(IDRs1), .IDRs2(IDRs2),
        .IDUsesRs1(IDUsesRs1), .IDUsesRs2(IDUsesRs2),
        .EXRegisterRd(EXRegisterRd), .EXMemRead(EXMemRead),
        .EXMulStart(EXMulStart), .branchTaken(branchTaken),
        .pcWrite(pcW[1]), .ifIdWrite(ifIdW[1]),
        .idExWrite(idExW[1]), .idExBubble(idExB[1]),
        .ifIdFlush(ifIdF[1]), .exMemBubble(exMemB[1]),
        .mulBusy(mulB[1]), .stallCycles(stC[1])
    );

    hazard_unit #(.AddressSize(5), .MulLatency(1)) u1 (
        .clk(clk), .arst_n(arst_n),
        .IDRs1(IDRs1), .IDRs2(IDRs2),
        .IDUsesRs1(IDUsesRs1), .IDUsesRs2(IDUsesRs2),
        .EXRegisterRd(EXRegisterRd), .EXMemRead(EXMemRead),
        .EXMulStart(EXMulStart), .branchTaken(branchTaken),
        .pcWrite(pcW[2]), .ifIdWrite(ifIdW[2]),
        .idExWrite(idExW[2]), .idExBubble(idExB[2]),
        .ifIdFlush(ifIdF[2]), .exMemBubble(exMemB[2]),
        .mulBusy(mulB[2]), .stallCycles(stC[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: remaining freeze cycles, release flag, stall count
    int     ml[3] = '{4, 2, 1};
    int     m_rem[3];
    bit     m_rel[3];
    longint m_cnt[3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_rem[k] = 0;
            m_rel[k] = 0;
            m_cnt[k] = 0;
        end
    end

    always @(negedge clk) begin
        bit lu;
        bit frz, flu, stl, started, nrel;
        n_checks++;
        if (EXMulStart && branchTaken) begin
            n_fail++;
            $display("FAIL illegal_mul_branch: got 1 expected 0");
        end
        lu = EXMemRead && (EXRegisterRd != 0) &&
             ((IDUsesRs1 && IDRs1 == EXRegisterRd) ||
              (IDUsesRs2 && IDRs2 == EXRegisterRd));
        for (int k = 0; k < 3; k++) begin
            if (!arst_n) begin
                m_rem[k] = 0;
                m_rel[k] = 0;
                m_cnt[k] = 0;
            end
            frz = 0; flu = 0; stl = 0; started = 0;
            if (m_rem[k] > 0) frz = 1;
            else if (branchTaken) flu = 1;
            else if (EXMulStart && !m_rel[k] && ml[k] >= 2) begin
                frz = 1;
                started = 1;
            end
            else if (lu) stl = 1;
            check($sformatf("pcWrite[ml%0d]", ml[k]),
                  64'(pcW[k]), 64'(!(frz || stl)));
            check($sformatf("ifIdWrite[ml%0d]", ml[k]),
                  64'(ifIdW[k]), 64'(!(frz || stl)));
            check($sformatf("idExWrite[ml%0d]", ml[k]),
                  64'(idExW[k]), 64'(!frz));
            check($sformatf("idExBubble[ml%0d]", ml[k]),
                  64'(idExB[k]), 64'(flu || stl));
            check($sformatf("ifIdFlush[ml%0d]", ml[k]),
                  64'(ifIdF[k]), 64'(flu));
            check($sformatf("exMemBubble[ml%0d]", ml[k]),
                  64'(exMemB[k]), 64'(frz));
            check($sformatf("mulBusy[ml%0d]", ml[k]),
                  64'(mulB[k]), 64'(frz));
            check($sformatf("stallCycles[ml%0d]", ml[k]),
                  64'(stC[k]), 64'(m_cnt[k]));
            if (arst_n) begin
                nrel = 0;
                if (m_rem[k] > 0) begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) nrel = 1;
                end else if (started) begin
                    m_rem[k] = ml[k] - 2;
                    nrel = (ml[k] == 2);
                end
                m_rel[k] = nrel;
                if ((frz || stl) && m_cnt[k] < 64'hFFFF_FFFF)
                    m_cnt[k]++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IDRs1 = 0; IDRs2 = 0;
        IDUsesRs1 = 0; IDUsesRs2 = 0;
        EXRegisterRd = 0; EXMemRead = 0;
        EXMulStart = 0; branchTaken = 0;
    endtask

    task automatic load_use();
        IDRs1 = 5; IDUsesRs1 = 1;
        IDRs2 = 1; IDUsesRs2 = 1;
        EXRegisterRd = 5; EXMemRead = 1;
        EXMulStart = 0; branchTaken = 0;
    endtask

    task automatic do_reset();
        arst_n = 0;
        idle();
        step();
        arst_n = 1;
    endtask

    initial begin
        arst_n = 0;
        idle();
        step();
        step();
        arst_n = 1;
        check("reset_pcWrite", 64'(pcW[0]), 64'd1);
        check("reset_stall", 64'(stC[0]), 64'd0);

        // load x5 ; add x6,x5,x1
        load_use();
        #1;
        check("lu_pcWrite", 64'(pcW[0]), 64'd0);
        check("lu_bubble", 64'(idExB[0]), 64'd1);
        step();
        idle();
        #1;
        check("lu_after_pc", 64'(pcW[0]), 64'd1);
        check("lu_count", 64'(stC[0]), 64'd1);

        // load to x0 / unused rs2
        EXMemRead = 1; EXRegisterRd = 0;
        IDRs1 = 0; IDUsesRs1 = 1;
        step();
        EXRegisterRd = 7; IDRs1 = 3;
        IDRs2 = 7; IDUsesRs2 = 0;
        step();
        idle();
        check("nostall_count", 64'(stC[0]), 64'd1);

        // branch wins over load-use
        load_use();
        branchTaken = 1;
        #1;
        check("br_pcWrite", 64'(pcW[0]), 64'd1);
        check("br_flush", 64'(ifIdF[0]), 64'd1);
        step();
        idle();
        check("br_count", 64'(stC[0]), 64'd1);

        // multiply held for 4 cycles
        do_reset();
        EXMulStart = 1;
        repeat (4) step();
        idle();
        repeat (2) step();
        check("mul4_count", 64'(stC[0]), 64'd3);
        check("mul1_count", 64'(stC[2]), 64'd0);

        do_reset();
        EXMulStart = 1;
        repeat (2) step();
        idle();
        repeat (3) step();
        check("mul2_count", 64'(stC[1]), 64'd1);

        // reset in the second MUL_BUSY cycle
        do_reset();
        EXMulStart = 1;
        step();
        step();
        check("mid_busy", 64'(mulB[0]), 64'd1);
        EXMulStart = 0;
        arst_n = 0;
        #1;
        check("rst_mulBusy", 64'(mulB[0]), 64'd0);
        check("rst_count", 64'(stC[0]), 64'd0);
        step();
        arst_n = 1;
        repeat (2) step();
        check("post_rst_idle", 64'(mulB[0]), 64'd0);
        EXMulStart = 1;
        #1;
        check("fresh_start", 64'(mulB[0]), 64'd1);
        repeat (4) step();
        idle();
        step();

        // saturation
        u4.r_stallCycles = 32'hFFFF_FFFE;
        u2.r_stallCycles = 32'hFFFF_FFFE;
        u1.r_stallCycles = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) m_cnt[k] = 64'hFFFF_FFFE;
        repeat (3) begin
            load_use();
            step();
        end
        idle();
        step();
        check("sat_count", 64'(stC[0]), 64'hFFFF_FFFF);

        // randomised traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            IDRs1        = 5'($urandom_range(0, 3));
            IDRs2        = 5'($urandom_range(0, 3));
            IDUsesRs1    = 1'($urandom);
            IDUsesRs2    = 1'($urandom);
            EXRegisterRd = 5'($urandom_range(0, 3));
            EXMemRead    = 1'($urandom);
            branchTaken  = ($urandom_range(0, 7) == 0);
            EXMulStart   = !branchTaken &&
                           ($urandom_range(0, 5) == 0);
            arst_n       = ($urandom_range(0, 199) != 0);
            step();
        end
        arst_n = 1;
        idle();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
